// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ps2_pkg
// Brief    : Shared prefix codes, prefix-FSM states and event record for PS/2.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : Synchronises PS/2 lines, assembles 11-bit frames, checks them and
//            aborts stalled frames with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int             WDW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  logic [1:0]     clk_sync_q, clk_sync_d;
  logic [1:0]     data_sync_q, data_sync_d;
  logic           clk_prev_q, clk_prev_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           byte_valid_q, byte_valid_d;
  logic [7:0]     byte_q, byte_d;
  logic           frame_err_q, frame_err_d;

  logic           fall;
  logic           data_bit;

  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign data_bit = data_sync_q[1];

  always_comb begin
    clk_sync_d   = {clk_sync_q[0], ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2_data};
    clk_prev_d   = clk_sync_q[1];
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    wdog_d       = wdog_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;

    if (fall) begin
      wdog_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is rejected on the spot; we stay hunting for a start.
        if (data_bit == 1'b0) begin
          bit_cnt_d = 4'd1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {data_bit, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        parity_d  = data_bit;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        bit_cnt_d = 4'd0;
        if (data_bit && ((^shift_q) ^ parity_q)) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (wdog_q == WD_LAST) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = 4'd0;
        shift_d     = 8'd0;
        wdog_d      = '0;
      end else begin
        wdog_d = wdog_q + WD_ONE;
      end
    end else begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      parity_q     <= 1'b0;
      wdog_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'd0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      wdog_q       <= wdog_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_sequencer
// Brief    : Folds E0/F0 prefixes into key events and buffers them in a FIFO
//            with a valid/ready handshake and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       frame_err,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_CAP = (AW+1)'(FIFO_DEPTH);

  logic       byte_valid;
  logic [7:0] byte_data;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  ps2_state_e  state_q, state_d;
  logic        push_q, push_d;
  ps2_evt_t    push_evt_q, push_evt_d;
  ps2_evt_t    mem_q [FIFO_DEPTH];
  ps2_evt_t    mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;

  logic [AW:0] count;
  logic        full;
  logic        pop;
  logic        accept;
  logic        drop;
  ps2_evt_t    head;

  always_comb begin
    state_d    = state_q;
    push_d     = 1'b0;
    push_evt_d = push_evt_q;

    if (frame_err) begin
      state_d = ST_IDLE;
    end else if (byte_valid) begin
      if (byte_data == PS2_PREFIX_EXT) begin
        case (state_q)
          ST_IDLE: state_d = ST_EXT;
          ST_BRK:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else if (byte_data == PS2_PREFIX_BRK) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        push_d          = 1'b1;
        push_evt_d.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        push_evt_d.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        push_evt_d.code = byte_data;
        state_d         = ST_IDLE;
      end
    end
  end

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == PTR_CAP);
  assign evt_valid = (wr_ptr_q != rd_ptr_q);
  assign pop       = evt_valid & evt_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign accept    = push_q & (~full | pop);
  assign drop      = push_q & full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_evt_q;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      push_q     <= 1'b0;
      push_evt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      push_q     <= push_d;
      push_evt_q <= push_evt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_code = head.code;
  assign evt_ext  = head.ext;
  assign evt_brk  = head.brk;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_sequencer
// Brief    : Drives PS/2 frames and checks key events against a prefix model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_sequencer;

  localparam int TIMEOUT = 300;
  localparam int DEPTH   = 4;
  localparam int HALF    = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid, evt_ext, evt_brk, frame_err, ovf;
  logic [7:0] evt_code;
  logic [9:0] dut_head;

  always #5 clk = ~clk;

  ps2_key_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_brk  (evt_brk),
    .frame_err(frame_err),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  assign dut_head = {evt_ext, evt_brk, evt_code};

  int         errors = 0;
  int         checks = 0;
  logic [9:0] exp_q[$];
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  bit         exp_ovf = 1'b0;
  int         exp_errs = 0;
  int         seen_errs = 0;
  int         pops = 0;
  logic [7:0] last_code = 8'h00;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: prefixes are two booleans; every other good byte becomes an event.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_errs++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    model_byte(b, !bad_par && !bad_stop);
    send_bits(bits, 11);
    wait_clks(3 * HALF);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_model_queue_empty", 32'(exp_q.size()), 32'd0);
    wait_clks(10);
  endtask

  // Compare process: pops against the model, head stability, frame_err width.
  bit         prev_valid = 1'b0;
  bit         prev_pop = 1'b0;
  bit         prev_err = 1'b0;
  logic [9:0] prev_head = '0;

  always @(negedge clk) begin
    if (resetn) begin
      if (frame_err) begin
        seen_errs++;
        check("frame_err_single_cycle", 32'(prev_err), 32'd0);
      end
      if (prev_valid && !prev_pop) begin
        check("head_held_valid", 32'(evt_valid), 32'd1);
        check("head_held_data", 32'(dut_head), 32'(prev_head));
      end
      if (evt_valid && evt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0h, expected no event", dut_head);
        end else if (dut_head !== exp_q[0]) begin
          errors++;
          $display("FAIL pop_event: got %0h, expected %0h", dut_head, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        pops++;
        last_code = evt_code;
      end
      prev_valid = evt_valid;
      prev_pop   = evt_valid && evt_ready;
      prev_err   = frame_err;
      prev_head  = dut_head;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) evt_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    logic [7:0] b;
    bit         bp, bs;

    #2 resetn = 1'b0;
    wait_clks(5);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_code", 32'(evt_code), 32'd0);
    check("rst_evt_ext", 32'(evt_ext), 32'd0);
    check("rst_evt_brk", 32'(evt_brk), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    resetn = 1'b1;
    wait_clks(5);

    evt_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0);
    drain();
    check("plain_1C_pops", 32'(pops), 32'd1);
    check("plain_1C_code", 32'(last_code), 32'h1C);
    check("plain_1C_no_err", 32'(seen_errs), 32'd0);

    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    drain();
    check("brk_1C_pops", 32'(pops), 32'd2);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    drain();
    check("ext_brk_75_pops", 32'(pops), 32'd3);

    send_frame(8'h1C, 1'b1, 1'b0);
    check("bad_parity_err", 32'(seen_errs), 32'd1);
    check("bad_parity_no_evt", 32'(pops), 32'd3);
    send_frame(8'h32, 1'b0, 1'b0);
    drain();
    check("after_err_32_code", 32'(last_code), 32'h32);

    model_byte(8'h00, 1'b0);
    send_bits(11'b000_0011_0100, 5);
    wait_clks(TIMEOUT + 100);
    check("timeout_err", 32'(seen_errs), 32'd2);
    send_frame(8'h5A, 1'b0, 1'b0);
    drain();
    check("after_timeout_5A_code", 32'(last_code), 32'h5A);
    check("after_timeout_pops", 32'(pops), 32'd5);

    evt_ready = 1'b0;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    wait_clks(10);
    check("stall_valid", 32'(evt_valid), 32'd1);
    check("stall_head", 32'(dut_head), 32'h375);
    evt_ready = 1'b1;
    drain();

    evt_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    send_frame(8'h21, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0);
    send_frame(8'h24, 1'b0, 1'b0);
    wait_clks(10);
    check("full_head_code", 32'(evt_code), 32'h1C);
    check("full_ovf_set", 32'(ovf), 32'd1);
    check("full_ovf_model", 32'(ovf), 32'(exp_ovf));
    evt_ready = 1'b1;
    drain();
    check("full_pops", 32'(pops), 32'd10);
    check("full_last_code", 32'(last_code), 32'h23);
    check("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    wait_clks(1);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    wait_clks(2);
    check("ovf_cleared", 32'(ovf), 32'd0);
    check("directed_errs", 32'(seen_errs), 32'(exp_errs));

    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hE0 || b == 8'hF0) b = b ^ 8'h01;
        end
      endcase
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 14) == 0);
      send_frame(b, bp, bs);
    end
    rand_ready = 1'b0;
    #1;
    evt_ready = 1'b1;
    drain();
    check("random_errs", 32'(seen_errs), 32'(exp_errs));
    check("random_ovf", 32'(ovf), 32'(exp_ovf));
    check("random_empty", 32'(evt_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
